imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Writer side of the instruction-memory interface: fills IMEM from a byte stream (UART receiver) while
//  holding the core, then releases it. Stream = 16-bit little-endian word count, then count x 4 bytes,
//  each word little-endian. Sits between the UART RX and the IMEM write port in top_riscv_wrapper.
// PARAMETERS
//  ADDR_WIDTH      10        IMEM word-address width; capacity = 2**ADDR_WIDTH words
//  TIMEOUT_CYCLES  1000000   max idle clk cycles between bytes once a load has started
// PORTS
//  clk          in   1           system clock
//  rst          in   1           synchronous reset, active-high
//  start        in   1           begin (or restart) a load; one-cycle pulse
//  rx_valid     in   1           rx_data valid this cycle; one-cycle pulse per byte
//  rx_data      in   8           received byte
//  imem_we      out  1           IMEM write strobe, one cycle per word
//  imem_addr    out  ADDR_WIDTH  IMEM word address
//  imem_wdata   out  32          IMEM write data
//  core_hold    out  1           1 = keep core in reset / PC stalled
//  done         out  1           load finished successfully (sticky)
//  err          out  1           load aborted: oversize count or timeout (sticky)
//  words_loaded out  16          words written in current/last load
// BEHAVIOUR
//  Sync reset, active-high: state=IDLE; core_hold=1; imem_we=0; imem_addr=0; imem_wdata=0;
//   done=0; err=0; words_loaded=0; byte index=0; timeout counter=0.
//  States: IDLE, LEN_LO, LEN_HI, DATA, DONE, ERROR.
//   IDLE   : start -> LEN_LO; clear done/err/words_loaded/imem_addr. rx_valid ignored.
//   LEN_LO : rx_valid -> count[7:0]=rx_data; -> LEN_HI.
//   LEN_HI : rx_valid -> count[15:8]=rx_data; count==0 -> DONE;
//            count > 2**ADDR_WIDTH -> ERROR; else -> DATA.
//   DATA   : rx_valid -> byte into word[8*idx+:8], idx=idx+1 (mod 4). On byte with idx==3:
//            next cycle imem_we=1, imem_wdata=assembled word, imem_addr=words_loaded[ADDR_WIDTH-1:0];
//            words_loaded+1 same edge. When words_loaded reaches count -> DONE (same edge as last we).
//   DONE   : core_hold=0, done=1. rx_valid ignored. start -> LEN_LO (reload, clears done).
//   ERROR  : core_hold=1, err=1, imem_we=0. rx_valid ignored. start -> LEN_LO (clears err).
//  core_hold=1 in every state except DONE; deasserts the cycle after the final imem_we.
//  Latency: last byte of a word on cycle N -> imem_we high on cycle N+1, exactly one cycle.
//  Timeout: counter runs in LEN_LO/LEN_HI/DATA, clears on every rx_valid and on state entry;
//   reaching TIMEOUT_CYCLES -> ERROR. Partial word is discarded, never written.
//  start in LEN_LO/LEN_HI/DATA is ignored (no restart mid-load).
//  start and rx_valid same cycle in IDLE/DONE/ERROR: start wins, byte dropped.
//  rx_valid on consecutive cycles accepted at full rate (one byte per clk).
//  rst mid-load: immediate return to reset values; IMEM contents already written are not touched.
//  Count == 2**ADDR_WIDTH is legal (fills IMEM exactly); imem_addr never wraps.
// TESTING
//  1. rst, start, bytes 02 00 | 13 00 00 00 | 6F 00 00 00 -> we@addr0=0x00000013, we@addr1=0x0000006F,
//     done=1, core_hold=0, words_loaded=2.
//  2. start, bytes 00 00 -> DONE immediately, no imem_we, core_hold=0.
//  3. ADDR_WIDTH=10, count 01 04 (1025) -> err=1, core_hold=1, no imem_we; start clears err.
//  4. count=1, send 3 data bytes then idle TIMEOUT_CYCLES -> ERROR, no imem_we, err=1.
//  5. count=2 with bytes back-to-back every clk -> two single-cycle we pulses, 4 clks apart.
//  6. rst asserted after 5 of 8 data bytes -> all outputs at reset values next cycle; later
//     start + full stream loads normally from addr 0.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader
//   Fills the instruction memory from a UART byte stream while holding the
//   core, then releases it. The stream starts with a 16-bit little-endian
//   word count, followed by that many 32-bit little-endian words.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high
//   start        one-cycle pulse: begin (or restart) a load
//   rx_valid     one-cycle pulse per received byte
//   rx_data      received byte
//   imem_we      IMEM write strobe, one cycle per word
//   imem_addr    IMEM word address
//   imem_wdata   IMEM write data
//   core_hold    1 keeps the core in reset / PC stalled
//   done         sticky: load finished successfully
//   err          sticky: load aborted (oversize count or timeout)
//   words_loaded words written in the current/last load
module imem_loader #(
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_hold,
  output logic                  done,
  output logic                  err,
  output logic [15:0]           words_loaded
);

  localparam int              TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [16:0]     CAP    = 17'(2 ** ADDR_WIDTH);
  localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, DONE, ERROR} state_t;

  state_t        state, state_next;
  logic [15:0]   count;
  logic [23:0]   word_lo;   // first three bytes of the word being assembled
  logic [1:0]    idx;
  logic [TW-1:0] tcnt;

  logic        active;
  logic        timeout_hit;
  logic        word_done;
  logic        last_word;
  logic [15:0] len;

  assign active      = (state == LEN_LO) || (state == LEN_HI) || (state == DATA);
  // tcnt has already counted T-1 idle cycles; this idle cycle is the T-th
  assign timeout_hit = active && !rx_valid && (tcnt == T_LAST);
  assign len         = {rx_data, count[7:0]};
  assign word_done   = (state == DATA) && rx_valid && (idx == 2'd3);
  assign last_word   = word_done && ((words_loaded + 16'd1) == count);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (start) state_next = LEN_LO;
      LEN_LO: begin
        if (timeout_hit)   state_next = ERROR;
        else if (rx_valid) state_next = LEN_HI;
      end
      LEN_HI: begin
        if (timeout_hit) state_next = ERROR;
        else if (rx_valid) begin
          if (len == 16'd0)             state_next = DONE;
          else if ({1'b0, len} > CAP)   state_next = ERROR;
          else                          state_next = DATA;
        end
      end
      DATA: begin
        if (timeout_hit)    state_next = ERROR;
        else if (last_word) state_next = DONE;
      end
      DONE:    if (start) state_next = LEN_LO;
      ERROR:   if (start) state_next = LEN_LO;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      core_hold    <= 1'b1;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
      idx          <= '0;
      tcnt         <= '0;
    end else begin
      imem_we   <= 1'b0;
      // Registered so the release lands the cycle after the final write,
      // and re-asserts as soon as a reload leaves DONE.
      core_hold <= !((state == DONE) && (state_next == DONE));

      if ((state_next != state) || rx_valid || !active) tcnt <= '0;
      else                                              tcnt <= tcnt + 1'b1;

      if (start && ((state == IDLE) || (state == DONE) || (state == ERROR))) begin
        done         <= 1'b0;
        err          <= 1'b0;
        words_loaded <= '0;
        imem_addr    <= '0;
        idx          <= '0;
      end

      if ((state == LEN_HI) && rx_valid) idx <= '0;

      if ((state == DATA) && rx_valid && !word_done) idx <= idx + 2'd1;

      if (word_done) begin
        idx          <= '0;
        imem_we      <= 1'b1;
        imem_wdata   <= {rx_data, word_lo};
        imem_addr    <= words_loaded[ADDR_WIDTH-1:0];
        words_loaded <= words_loaded + 16'd1;
      end

      if ((state_next == DONE) && (state != DONE))   done <= 1'b1;
      if ((state_next == ERROR) && (state != ERROR)) err  <= 1'b1;
    end
  end

  // Count and partial-word bytes carry no reset; they are always written
  // before use in a load.
  always_ff @(posedge clk) begin
    if ((state == LEN_LO) && rx_valid) count[7:0]  <= rx_data;
    if ((state == LEN_HI) && rx_valid) count[15:8] <= rx_data;
    if ((state == DATA) && rx_valid) begin
      case (idx)
        2'd0:    word_lo[7:0]   <= rx_data;
        2'd1:    word_lo[15:8]  <= rx_data;
        2'd2:    word_lo[23:16] <= rx_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Randomised byte-stream stimulus for imem_loader. The driver pushes the
//   expected IMEM writes (address, word) into a queue as it decides the
//   stream; an independent monitor pops and compares on every write strobe.
module tb_imem_loader;

  localparam int AW  = 10;
  localparam int TO  = 40;
  localparam int CAP = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_hold;
  logic          done;
  logic          err;
  logic [15:0]   words_loaded;

  imem_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_hold(core_hold), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int we_cnt = 0;
  int we_last_cyc = 0;
  int we_prev_cyc = 0;
  logic [41:0] sb[$];   // {addr[9:0], data[31:0]}

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && imem_we) begin
      logic [41:0] e;
      we_cnt++;
      we_prev_cyc = we_last_cyc;
      we_last_cyc = cyc;
      check("we_core_hold", {31'd0, core_hold}, 32'd1);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_we: addr 0x%0h data 0x%0h, none expected", imem_addr, imem_wdata);
      end else begin
        e = sb.pop_front();
        check("we_addr", {22'd0, imem_addr}, {22'd0, e[41:32]});
        check("we_data", imem_wdata, e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit st);
    rx_valid = 1'b1;
    rx_data  = b;
    start    = st;
    tick();
    rx_valid = 1'b0;
    start    = 1'b0;
    repeat (gap) tick();
  endtask

  // Start pulse, sometimes colliding with a byte that must be dropped.
  task automatic start_pulse();
    start = 1'b1;
    if ($urandom_range(1, 0) == 1) begin
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
    end
    tick();
    start    = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic check_final(input int cnt, input int wc0);
    if (cnt <= CAP) begin
      check("done", {31'd0, done}, 32'd1);
      check("err", {31'd0, err}, 32'd0);
      check("core_hold_rel", {31'd0, core_hold}, 32'd0);
      check("words_loaded", {16'd0, words_loaded}, 32'(cnt));
    end else begin
      check("err_set", {31'd0, err}, 32'd1);
      check("done_clr", {31'd0, done}, 32'd0);
      check("core_hold_err", {31'd0, core_hold}, 32'd1);
      check("no_we_err", 32'(we_cnt - wc0), 32'd0);
    end
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic run_load(input int cnt, input bit do_start, input int gapmax, input bit noise);
    int wc0;
    logic [31:0] w;
    logic [15:0] c16;
    wc0 = we_cnt;
    c16 = 16'(cnt);
    if (do_start) start_pulse();
    send_byte(c16[7:0],  $urandom_range(gapmax, 0), 1'b0);
    send_byte(c16[15:8], $urandom_range(gapmax, 0), 1'b0);
    if (cnt <= CAP) begin
      for (int i = 0; i < cnt; i++) begin
        w = $urandom;
        sb.push_back({10'(i), w});
        for (int b = 0; b < 4; b++)
          send_byte(w[8*b +: 8], $urandom_range(gapmax, 0),
                    noise && ($urandom_range(7, 0) == 0));
      end
    end
    repeat (3) tick();
    check_final(cnt, wc0);
  endtask

  initial begin
    int wc0;
    logic [31:0] w;

    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
    repeat (3) tick();
    check("rst_we", {31'd0, imem_we}, 32'd0);
    check("rst_addr", {22'd0, imem_addr}, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_hold", {31'd0, core_hold}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_words", {16'd0, words_loaded}, 32'd0);
    rst = 1'b0;
    tick();

    // Reference stream: two instructions
    start_pulse();
    sb.push_back({10'd0, 32'h0000_0013});
    sb.push_back({10'd1, 32'h0000_006F});
    send_byte(8'h02, 0, 0); send_byte(8'h00, 1, 0);
    send_byte(8'h13, 0, 0); send_byte(8'h00, 2, 0); send_byte(8'h00, 0, 0); send_byte(8'h00, 0, 0);
    send_byte(8'h6F, 1, 0); send_byte(8'h00, 0, 0); send_byte(8'h00, 0, 0); send_byte(8'h00, 0, 0);
    repeat (3) tick();
    check_final(2, 0);

    // Zero-length load, then bytes in DONE are ignored
    wc0 = we_cnt;
    run_load(0, 1, 2, 0);
    send_byte(8'hAA, 0, 0); send_byte(8'h55, 2, 0);
    check("done_ignore_rx", {31'd0, done}, 32'd1);
    check("zero_no_we", 32'(we_cnt - wc0), 32'd0);

    // Oversize count, start clears err, then the load proceeds without a new start
    run_load(CAP + 1, 1, 1, 0);
    start_pulse();
    check("err_cleared", {31'd0, err}, 32'd0);
    check("hold_after_restart", {31'd0, core_hold}, 32'd1);
    run_load(1, 0, 2, 0);

    // Timeout after a partial word
    wc0 = we_cnt;
    start_pulse();
    send_byte(8'h01, 0, 0); send_byte(8'h00, 0, 0);
    send_byte(8'h11, 0, 0); send_byte(8'h22, 0, 0); send_byte(8'h33, 0, 0);
    repeat (TO - 2) tick();
    check("err_before_timeout", {31'd0, err}, 32'd0);
    repeat (4) tick();
    check("timeout_err", {31'd0, err}, 32'd1);
    check("timeout_hold", {31'd0, core_hold}, 32'd1);
    check("timeout_no_we", 32'(we_cnt - wc0), 32'd0);

    // Back-to-back bytes: write strobes four cycles apart
    wc0 = we_cnt;
    run_load(2, 1, 0, 0);
    check("b2b_we_count", 32'(we_cnt - wc0), 32'd2);
    check("b2b_we_spacing", 32'(we_last_cyc - we_prev_cyc), 32'd4);

    // Random loads with random gaps and ignored mid-load start pulses
    for (int k = 0; k < 8; k++) run_load($urandom_range(20, 1), 1, 3, 1);

    // Exactly full IMEM
    run_load(CAP, 1, 1, 0);

    // Reset in the middle of the second word
    start_pulse();
    send_byte(8'h02, 0, 0); send_byte(8'h00, 0, 0);
    w = $urandom;
    sb.push_back({10'd0, w});
    for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], 0, 0);
    send_byte(8'hEE, 0, 0);
    rst = 1'b1;
    tick();
    check("mid_rst_we", {31'd0, imem_we}, 32'd0);
    check("mid_rst_addr", {22'd0, imem_addr}, 32'd0);
    check("mid_rst_wdata", imem_wdata, 32'd0);
    check("mid_rst_hold", {31'd0, core_hold}, 32'd1);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_words", {16'd0, words_loaded}, 32'd0);
    check("mid_rst_sb", 32'(sb.size()), 32'd0);
    rst = 1'b0;
    tick();
    run_load(2, 1, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
